// File: rtl/jt51_op_exp_if.sv
// jt51_op_exp_if: sample bus between the level summing stage and the operator accumulator
interface jt51_op_exp_if #(parameter int OUT_W = 14);
  logic in_valid;
  logic [12:0] att;
  logic sign;
  logic out_valid;
  logic signed [OUT_W-1:0] out;
  modport master(output in_valid, att, sign, input out_valid, out);
  modport slave(input in_valid, att, sign, output out_valid, out);
endinterface

// File: rtl/jt51_op_exp.sv
// jt51_op_exp: log-domain operator level to signed linear sample via exponent ROM and shifter
module jt51_op_exp #(parameter int OUT_W = 14) (
  input logic clk,
  input logic rst_n,
  input logic cen,
  jt51_op_exp_if.slave bus
);
  // exp[a] = 65536*(2^(1-(a+1)/256)-1), built by repeated multiplication by 2^(-1/256) in Q30
  function automatic logic [4095:0] rom_init();
    logic [63:0] p;
    logic [4095:0] t;
    p = 64'd1 << 31;
    t = '0;
    for (int a = 0; a < 256; a++) begin
      p = (p * 64'd4283353945) >> 32;
      t[a*16 +: 16] = 16'(((p + 64'd8192) >> 14) - 64'd65536);
    end
    return t;
  endfunction
  localparam logic [4095:0] ROM = rom_init();
  localparam logic [5:0] SH_BIAS = 6'(18 - OUT_W);
  logic [12:0] att1;
  logic sign1, v1, sign2, v2;
  logic [4:0] e2;
  logic [15:0] exp2;
  logic [5:0] sh;
  logic [OUT_W-2:0] mag;
  always_ff @(posedge clk)
    if (cen) exp2 <= ROM[{att1[7:0], 4'd0} +: 16];
  always_comb begin
    sh = {1'b0, e2} + SH_BIAS;
    mag = sh >= 6'd17 ? '0 : (OUT_W-1)'({1'b1, exp2} >> sh);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      att1 <= '0;
      sign1 <= 1'b0;
      v1 <= 1'b0;
      e2 <= '0;
      sign2 <= 1'b0;
      v2 <= 1'b0;
      bus.out <= '0;
      bus.out_valid <= 1'b0;
    end else if (cen) begin
      att1 <= bus.att;
      sign1 <= bus.sign;
      v1 <= bus.in_valid;
      e2 <= att1[12:8];
      sign2 <= sign1;
      v2 <= v1;
      bus.out <= sign2 ? -{1'b0, mag} : {1'b0, mag};
      bus.out_valid <= v2;
    end
endmodule

// File: tb/tb_jt51_op_exp.sv
// tb_jt51_op_exp: directed vectors for OUT_W=14 and OUT_W=16 against a real-valued exponent model
module tb_jt51_op_exp;
  typedef struct packed {logic v; logic [12:0] att; logic sign;} smp_t;
  logic clk = 0, rst_n = 0, cen = 0, in_valid = 0, sign = 0;
  logic [12:0] att = '0;
  int errors = 0, checks = 0;
  bit chk_on = 0, sweeping = 0, pcen = 0, prst = 0;
  int last14 = 0, last16 = 0;
  int sw [256];
  smp_t q[$];
  smp_t cur = '0;
  jt51_op_exp_if #(.OUT_W(14)) b14();
  jt51_op_exp_if #(.OUT_W(16)) b16();
  assign b14.in_valid = in_valid;
  assign b14.att = att;
  assign b14.sign = sign;
  assign b16.in_valid = in_valid;
  assign b16.att = att;
  assign b16.sign = sign;
  jt51_op_exp #(.OUT_W(14)) dut14(.clk(clk), .rst_n(rst_n), .cen(cen), .bus(b14));
  jt51_op_exp #(.OUT_W(16)) dut16(.clk(clk), .rst_n(rst_n), .cen(cen), .bus(b16));
  always #5 clk = ~clk;

  function automatic int model(logic [12:0] a, logic s, int w);
    int m, sh, mag;
    m = $rtoi(65536.0 * $pow(2.0, 1.0 - real'(int'(a[7:0]) + 1) / 256.0) + 0.5);
    sh = int'(a[12:8]) + 18 - w;
    mag = sh >= 17 ? 0 : m >> sh;
    return s ? -mag : mag;
  endfunction

  task automatic chk(string n, int act, int exp, int tol);
    checks++;
    if (act > exp + tol || act < exp - tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic step(logic c, logic v, logic [12:0] a, logic s);
    cen = c;
    in_valid = v;
    att = a;
    sign = s;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic lit(string n, logic [12:0] a, logic s, int e14, int e16);
    step(1, 1, a, s);
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    chk({n, "_14"}, int'(b14.out), e14, 0);
    chk({n, "_16"}, int'(b16.out), e16, 0);
  endtask

  always @(posedge clk) begin
    pcen = cen;
    prst = rst_n;
    if (!rst_n) begin
      q.delete();
      cur = '0;
    end else if (cen) begin
      q.push_back({in_valid, att, sign});
      if (q.size() == 3) cur = q.pop_front();
    end
  end

  always @(negedge clk)
    if (chk_on) begin
      chk("valid14", int'(b14.out_valid), int'(cur.v), 0);
      chk("valid16", int'(b16.out_valid), int'(cur.v), 0);
      if (cur.v) begin
        chk("out14", int'(b14.out), model(cur.att, cur.sign, 14), 1);
        chk("out16", int'(b16.out), model(cur.att, cur.sign, 16), 1);
        if (sweeping) sw[cur.att[7:0]] = int'(b16.out);
      end
      if (prst && !pcen) begin
        chk("hold14", int'(b14.out), last14, 0);
        chk("hold16", int'(b16.out), last16, 0);
      end
      last14 = int'(b14.out);
      last16 = int'(b16.out);
    end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", int'(b14.out), 0, 0);
    chk("rst_valid", int'(b14.out_valid), 0, 0);
    rst_n = 1;
    chk_on = 1;
    lit("pos0", 13'h000, 0, 8169, 32679);
    lit("neg0", 13'h000, 1, -8169, -32679);
    lit("a0ff", 13'h0ff, 0, 4096, 16384);
    lit("a1ff", 13'h1ff, 0, 2048, 8192);
    lit("a100", 13'h100, 0, 4084, 16339);
    lit("acff", 13'hcff, 0, 1, 4);
    lit("ad00", 13'hd00, 0, 0, 3);
    lit("ad00n", 13'hd00, 1, 0, -3);
    step(1, 1, 13'h000, 0);
    step(1, 1, 13'h0ff, 0);
    step(1, 1, 13'h1ff, 0);
    chk("s0", int'(b14.out), 8169, 0);
    step(1, 0, '0, 0);
    chk("s1", int'(b14.out), 4096, 0);
    step(1, 0, '0, 0);
    chk("s2", int'(b14.out), 2048, 0);
    step(1, 1, 13'h000, 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    step(1, 1, 13'h0ff, 0);
    step(0, 1, 13'h155, 1);
    step(1, 1, 13'h1ff, 1);
    step(1, 0, '0, 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    step(1, 1, 13'h000, 0);
    step(1, 1, 13'h0ff, 0);
    rst_n = 0;
    step(0, 0, '0, 0);
    chk("rst2_out", int'(b14.out), 0, 0);
    chk("rst2_valid", int'(b14.out_valid), 0, 0);
    rst_n = 1;
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    step(1, 1, 13'h0ff, 0);
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    chk("post_rst_out", int'(b14.out), 4096, 0);
    chk("post_rst_valid", int'(b14.out_valid), 1, 0);
    sweeping = 1;
    for (int a = 0; a < 256; a++) step(1, 1, {5'd0, 8'(a)}, 0);
    repeat (3) step(1, 0, '0, 0);
    sweeping = 0;
    chk("sw_first", sw[0], 32679, 0);
    chk("sw_last", sw[255], 16384, 0);
    for (int a = 1; a < 256; a++) begin
      checks++;
      if (sw[a] > sw[a-1]) begin
        errors++;
        $display("FAIL mono[%0d]: got %0d after %0d, required non-increasing", a, sw[a], sw[a-1]);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
